// File: rtl/pipe_skid_stage_pkg.sv
// Shared constants and payload layout for the inter-stage pipeline registers.
package pipe_skid_stage_pkg;

  // Default payload and occupancy widths
  localparam int unsigned DataW = 96;
  localparam int unsigned CntW  = 2;

  // Reset level helpers for stages that test the reset line explicitly
  localparam logic ResetEnable  = 1'b1;
  localparam logic ResetDisable = 1'b0;

  // Payload field widths shared by all stages
  localparam int unsigned AddrLen    = 32;
  localparam int unsigned RegLen     = 32;
  localparam int unsigned RegAddrLen = 5;
  localparam int unsigned OpCodeLen  = 8;
  localparam int unsigned OpSelLen   = 3;
  localparam int unsigned WrEnLen    = 1;
  localparam int unsigned PadLen     = DataW - (AddrLen + RegLen + RegAddrLen
                                                + OpCodeLen + OpSelLen + WrEnLen);

  // Payload field offsets (LSB positions), packed from the top down
  localparam int unsigned PcLsb     = DataW - AddrLen;
  localparam int unsigned OperLsb   = PcLsb - RegLen;
  localparam int unsigned RdLsb     = OperLsb - RegAddrLen;
  localparam int unsigned AluOpLsb  = RdLsb - OpCodeLen;
  localparam int unsigned AluSelLsb = AluOpLsb - OpSelLen;
  localparam int unsigned WrEnLsb   = AluSelLsb - WrEnLen;

  // All-zero payload: a bubble with write-enable and aluop cleared is a NOP
  localparam logic [DataW-1:0] ZERO_WORD = '0;

  // Stage payload as seen by the instantiating stages
  typedef struct packed {
    logic [AddrLen-1:0]    pc;
    logic [RegLen-1:0]     operand;
    logic [RegAddrLen-1:0] rd;
    logic [OpCodeLen-1:0]  aluop;
    logic [OpSelLen-1:0]   alusel;
    logic [WrEnLen-1:0]    wr_en;
    logic [PadLen-1:0]     pad;
  } stage_payload_t;

  // Handshake state, encoded as {main_valid, skid_valid}
  typedef enum logic [1:0] {
    StEmpty   = 2'b00,
    StIllegal = 2'b01,
    StOne     = 2'b10,
    StFull    = 2'b11
  } stage_state_e;

  // Pack a structured payload into the flat stage bus
  function automatic logic [DataW-1:0] pack_payload(input stage_payload_t p);
    return DataW'(p);
  endfunction

  // Unpack the flat stage bus into its fields
  function automatic stage_payload_t unpack_payload(input logic [DataW-1:0] w);
    return stage_payload_t'(w);
  endfunction

endpackage

// File: rtl/pipe_skid_stage_slot.sv
// One valid+data holding register with load, clear and valid-only kill.
module pipe_slot #(
  parameter int unsigned DATA_W = 96
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_i,
  input  logic              clr_i,
  input  logic              kill_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Next slot contents: clear beats load, load beats kill
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (ld_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (kill_i) begin
      valid_d = 1'b0;
    end
  end

  // Slot register with async reset to an empty, zeroed entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Generic inter-stage pipeline register with a 2-entry skid buffer and flush.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int unsigned DATA_W      = DataW,
  parameter bit          ZERO_BUBBLE = 1'b1,
  parameter int unsigned CNT_W       = CntW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  occupancy
);

  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data,  s_data;
  logic [DATA_W-1:0] m_din;
  logic              m_ld, m_clr, m_kill, m_from_skid;
  logic              s_ld, s_clr;
  logic              nxt_m_valid, nxt_s_valid;
  logic              accept_c, send_c;
  stage_state_e      state_c;

  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  occ_q, occ_d;

  // Slot valids are the state register; view them as the handshake state
  assign state_c  = stage_state_e'({m_valid, s_valid});
  assign accept_c = in_valid & in_ready_q;
  assign send_c   = m_valid & out_ready;

  // Next-state and slot controls; flush empties the stage, a send still completes
  always_comb begin
    m_ld        = 1'b0;
    m_clr       = 1'b0;
    m_kill      = 1'b0;
    m_from_skid = 1'b0;
    s_ld        = 1'b0;
    s_clr       = 1'b0;
    nxt_m_valid = m_valid;
    nxt_s_valid = s_valid;
    if (flush_i) begin
      m_clr       = 1'b1;
      s_clr       = 1'b1;
      nxt_m_valid = 1'b0;
      nxt_s_valid = 1'b0;
    end else begin
      unique case (state_c)
        StEmpty: begin
          if (accept_c) begin
            m_ld        = 1'b1;
            nxt_m_valid = 1'b1;
          end
        end
        StOne: begin
          if (accept_c && send_c) begin
            m_ld = 1'b1;
          end else if (send_c) begin
            nxt_m_valid = 1'b0;
            if (ZERO_BUBBLE) begin
              m_clr = 1'b1;
            end else begin
              m_kill = 1'b1;
            end
          end else if (accept_c) begin
            s_ld        = 1'b1;
            nxt_s_valid = 1'b1;
          end
        end
        StFull: begin
          if (send_c) begin
            m_ld        = 1'b1;
            m_from_skid = 1'b1;
            s_clr       = 1'b1;
            nxt_s_valid = 1'b0;
          end
        end
        default: begin
          m_clr       = 1'b1;
          s_clr       = 1'b1;
          nxt_m_valid = 1'b0;
          nxt_s_valid = 1'b0;
        end
      endcase
    end
  end

  // Main slot refills from skid when draining FULL, otherwise from upstream
  assign m_din = m_from_skid ? s_data : in_data;

  // Main slot drives the downstream outputs
  pipe_slot #(.DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .ld_i    (m_ld),
    .clr_i   (m_clr),
    .kill_i  (m_kill),
    .data_i  (m_din),
    .valid_o (m_valid),
    .data_o  (m_data)
  );

  // Skid slot catches the beat accepted while downstream stalled
  pipe_slot #(.DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .ld_i    (s_ld),
    .clr_i   (s_clr),
    .kill_i  (1'b0),
    .data_i  (in_data),
    .valid_o (s_valid),
    .data_o  (s_data)
  );

  // Ready and occupancy derived from the next slot valids
  always_comb begin
    in_ready_d = ~nxt_s_valid;
    occ_d      = CNT_W'(nxt_m_valid) + CNT_W'(nxt_s_valid);
  end

  // Registered ready and occupancy so neither depends on out_ready this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q <= 1'b1;
      occ_q      <= '0;
    end else begin
      in_ready_q <= in_ready_d;
      occ_q      <= occ_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign occupancy = occ_q;

  // Skid may only hold an entry while main holds one
  a_no_illegal_state: assert property (@(posedge clk) disable iff (rst)
    state_c != StIllegal);

  // Bubbles present an all-zero payload
  a_zero_bubble: assert property (@(posedge clk) disable iff (rst)
    (!ZERO_BUBBLE || m_valid || (m_data == '0)));

  // Registered ready always mirrors an empty skid slot
  a_ready_tracks_skid: assert property (@(posedge clk) disable iff (rst)
    in_ready_q == ~s_valid);

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and random bench for pipe_skid_stage with a queue-based reference model.
module tb_pipe_skid_stage;

  localparam int unsigned W = 96;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         flush_i;
  logic [1:0]   occupancy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq[$];        // model: entries held by the stage, oldest first
  logic [W-1:0] exp_sent[$];  // model: beats handed downstream
  logic [W-1:0] dut_log[$];   // observed handshakes on the DUT output
  bit           m_acc, m_snd;

  pipe_skid_stage #(.DATA_W(W), .ZERO_BUBBLE(1'b1), .CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush_i   (flush_i),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a FIFO of at most two entries; ready while fewer than two held
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else begin
      m_acc = in_valid && (mq.size() < 2);
      m_snd = out_ready && (mq.size() > 0);
      if (m_snd) begin
        exp_sent.push_back(mq[0]);
        void'(mq.pop_front());
      end
      if (flush_i) mq.delete();
      else if (m_acc) mq.push_back(in_data);
    end
  end

  // Compare DUT outputs against the model every cycle, mid-period
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", W'(out_valid), W'(mq.size() > 0));
      chk("out_data", out_data, (mq.size() > 0) ? mq[0] : '0);
      chk("in_ready", W'(in_ready), W'(mq.size() < 2));
      chk("occupancy", W'(occupancy), W'(mq.size()));
      chk("no_x", W'($isunknown({in_ready, out_valid, out_data, occupancy})), '0);
      if (out_valid && out_ready) dut_log.push_back(out_data);
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush_i   = f;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic ov, input logic [W-1:0] od,
                          input logic ir, input logic [1:0] oc);
    chk({tag, "_out_valid"}, W'(out_valid), W'(ov));
    chk({tag, "_out_data"}, out_data, od);
    chk({tag, "_in_ready"}, W'(in_ready), W'(ir));
    chk({tag, "_occupancy"}, W'(occupancy), W'(oc));
  endtask

  // Flip out_ready inside the cycle; in_ready must not move
  task automatic toggle_ready_check(input string tag);
    logic ir0;
    ir0 = in_ready;
    out_ready = ~out_ready;
    #1;
    chk(tag, W'(in_ready), W'(ir0));
    out_ready = ~out_ready;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int start;
    int pv, pr;
    logic iv, orr;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_outs("reset", 1'b0, '0, 1'b1, 2'd0);

    // Streaming 1..10 with downstream always ready
    start = dut_log.size();
    for (int i = 1; i <= 10; i++) drive(1'b1, W'(i), 1'b1, 1'b0);
    chk_outs("stream_mid", 1'b1, W'(10), 1'b1, 2'd1);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("stream_count", W'(dut_log.size() - start), W'(10));
    for (int i = 0; i < 10; i++)
      if (start + i < dut_log.size()) chk("stream_data", dut_log[start + i], W'(i + 1));

    // Backpressure: A to main, B to skid, C held upstream
    start = dut_log.size();
    drive(1'b1, W'(96'hA), 1'b0, 1'b0);
    drive(1'b1, W'(96'hB), 1'b0, 1'b0);
    drive(1'b1, W'(96'hC), 1'b0, 1'b0);
    chk_outs("bp_full", 1'b1, W'(96'hA), 1'b0, 2'd2);
    toggle_ready_check("bp_full_ready_stable");
    drive(1'b1, W'(96'hC), 1'b1, 1'b0);
    chk_outs("bp_drain1", 1'b1, W'(96'hB), 1'b1, 2'd1);
    drive(1'b1, W'(96'hC), 1'b1, 1'b0);
    chk_outs("bp_drain2", 1'b1, W'(96'hC), 1'b1, 2'd1);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("bp_count", W'(dut_log.size() - start), W'(3));
    if (dut_log.size() >= start + 3) begin
      chk("bp_first", dut_log[start], W'(96'hA));
      chk("bp_second", dut_log[start + 1], W'(96'hB));
      chk("bp_third", dut_log[start + 2], W'(96'hC));
    end

    // Flush while FULL with a concurrent incoming D
    start = dut_log.size();
    drive(1'b1, W'(96'hE), 1'b0, 1'b0);
    drive(1'b1, W'(96'hF), 1'b0, 1'b0);
    drive(1'b1, W'(96'hD), 1'b0, 1'b1);
    chk_outs("flush_full", 1'b0, '0, 1'b1, 2'd0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("flush_full_nothing_sent", W'(dut_log.size() - start), W'(0));

    // Flush with a concurrent send: the send still completes
    start = dut_log.size();
    drive(1'b1, W'(96'h5A5), 1'b0, 1'b0);
    toggle_ready_check("one_ready_stable");
    drive(1'b0, '0, 1'b1, 1'b1);
    chk_outs("flush_send", 1'b0, '0, 1'b1, 2'd0);
    chk("flush_send_count", W'(dut_log.size() - start), W'(1));
    if (dut_log.size() > start) chk("flush_send_data", dut_log[start], W'(96'h5A5));
    drive(1'b0, '0, 1'b0, 1'b0);

    // Asynchronous reset mid-run while FULL
    drive(1'b1, W'(96'h111), 1'b0, 1'b0);
    drive(1'b1, W'(96'h222), 1'b0, 1'b0);
    chk_outs("pre_rst_full", 1'b1, W'(96'h111), 1'b0, 2'd2);
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk_outs("async_rst", 1'b0, '0, 1'b1, 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_outs("post_rst", 1'b0, '0, 1'b1, 2'd0);

    // Random valid/ready traffic with varying pressure
    pv = 50; pr = 50;
    for (int i = 0; i < 10000; i++) begin
      if (i % 1000 == 0) begin
        pv = $urandom_range(10, 95);
        pr = $urandom_range(10, 95);
      end
      iv  = ($urandom_range(0, 99) < pv);
      orr = ($urandom_range(0, 99) < pr);
      drive(iv, iv ? {$urandom(), $urandom(), $urandom()} : 'x, orr, 1'b0);
      if (i % 16 == 0) toggle_ready_check("rand_ready_stable");
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    // Whole-run order check of everything the DUT handed downstream
    chk("sent_total", W'(dut_log.size()), W'(exp_sent.size()));
    for (int i = 0; i < dut_log.size() && i < exp_sent.size(); i++) begin
      if (dut_log[i] !== exp_sent[i]) begin
        chk("sent_order", dut_log[i], exp_sent[i]);
        break;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
